// File: rtl/rr_mux_arbiter_8.sv
// rr_mux_arbiter_8
// Round-robin arbiter for eight requesters sharing one 8:1 datapath.
// One requester owns the path at a time. The downstream mux select follows
// the owner. A rotating priority pointer keeps arbitration fair, and a single
// grant lasts at most MAX_HOLD consecutive cycles.
//
// Ports:
//   clk      - system clock, rising edge active
//   rst_n    - asynchronous active-low reset
//   req      - request vector, bit k = requester k wants the path
//   gnt      - one-hot grant vector, all zero when the path is idle
//   sel      - binary index of the current (or most recent) owner
//   busy     - high while a grant is active
//   hold_cnt - cycles the current grant has been held (1-based), 0 when idle
module rr_mux_arbiter_8 #(
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       req,
    output logic [7:0]       gnt,
    output logic [2:0]       sel,
    output logic             busy,
    output logic [CNT_W-1:0] hold_cnt
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t     state_r;
    logic [2:0] ptr_r;
    logic [2:0] owner_r;

    logic       release_s;
    logic [2:0] search_ptr_s;
    logic [3:0] win_s;

    // Circular priority search. Bit 3 of the result flags a winner, and bits
    // [2:0] hold its index. The loop runs from the lowest priority up to the
    // highest, so the index nearest to p is written last and wins.
    function automatic logic [3:0] rr_search(input logic [7:0] r, input logic [2:0] p);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'd0;
        for (int i = 7; i >= 0; i--) begin
            idx = p + 3'(i);
            if (r[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Release detection and search-start selection. On a release, the search
    // starts just past the old owner. The pointer update and the search happen
    // in the same cycle, so the handover has no idle bubble.
    always_comb begin
        release_s    = 1'b0;
        search_ptr_s = ptr_r;
        if (state_r == ST_GRANT) begin
            release_s    = (req[owner_r] == 1'b0) || (hold_cnt == CNT_W'(MAX_HOLD));
            search_ptr_s = owner_r + 3'd1;
        end else begin
            release_s    = 1'b0;
            search_ptr_s = ptr_r;
        end
        win_s = rr_search(req, search_ptr_s);
    end

    // Arbitration state machine with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            ptr_r    <= 3'd0;
            owner_r  <= 3'd0;
            gnt      <= 8'd0;
            sel      <= 3'd0;
            busy     <= 1'b0;
            hold_cnt <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (win_s[3]) begin
                        state_r  <= ST_GRANT;
                        owner_r  <= win_s[2:0];
                        gnt      <= 8'd1 << win_s[2:0];
                        sel      <= win_s[2:0];
                        busy     <= 1'b1;
                        hold_cnt <= CNT_W'(1);
                    end else begin
                        // sel keeps the last owner index while idle
                        state_r  <= ST_IDLE;
                        gnt      <= 8'd0;
                        busy     <= 1'b0;
                        hold_cnt <= '0;
                    end
                end
                ST_GRANT: begin
                    if (!release_s) begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end else begin
                        ptr_r <= owner_r + 3'd1;
                        if (win_s[3]) begin
                            owner_r  <= win_s[2:0];
                            gnt      <= 8'd1 << win_s[2:0];
                            sel      <= win_s[2:0];
                            busy     <= 1'b1;
                            hold_cnt <= CNT_W'(1);
                        end else begin
                            state_r  <= ST_IDLE;
                            gnt      <= 8'd0;
                            busy     <= 1'b0;
                            hold_cnt <= '0;
                        end
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    gnt      <= 8'd0;
                    busy     <= 1'b0;
                    hold_cnt <= '0;
                end
            endcase
        end
    end

endmodule
